mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Arbitrates and sequences all accesses to the 4096x16 main memory in the basic computer.
- Sits directly upstream of the memory block. It drives the memory's adress/read/write/indata inputs and captures its registered outdata.
- Serves two requesters: the instruction-fetch path (port f) and the operand/data path of the control unit (port d).
- Guarantees one command per access, never read and write together, and a fixed 3-cycle request-to-done latency.

Parameters:
AW, 12, address width (memory depth 2**AW words)
DW, 16, data word width

Ports:
clk  input  1  system clock; all state updates on posedge clk
reset  input  1  synchronous, active-high reset; sampled on posedge clk
f_req  input  1  fetch read request, level, held until f_done
f_addr  input  AW  fetch address (PC)
f_done  output  1  one-cycle pulse: fetch complete, f_rdata valid
f_rdata  output  DW  fetched instruction word, held until next fetch done
d_req  input  1  data request, level, held until d_done
d_we  input  1  1 = write, 0 = read; qualified by d_req
d_addr  input  AW  data address (AR)
d_wdata  input  DW  write data
d_done  output  1  one-cycle pulse: data access complete; d_rdata valid if read
d_rdata  output  DW  read data, held until next data read done
busy  output  1  high while an access is in ISSUE or CAPTURE
mem_adress  output  AW  to memory adress
mem_read  output  1  to memory read
mem_write  output  1  to memory write
mem_indata  output  DW  to memory indata
mem_outdata  input  DW  from memory outdata (registered, updated at posedge)

Behaviour:
- Reset values (after reset edge): state IDLE; f_done=0, d_done=0, f_rdata=0, d_rdata=0, busy=0; mem_read=0, mem_write=0, mem_adress=0, mem_indata=0; last_grant=F. With last_grant=F, d wins the first tie.
- States: IDLE, ISSUE, CAPTURE. All outputs are registered or decoded from registered state only.
- IDLE:
  - Effective requests: f_req & ~f_done and d_req & ~d_done. A request is masked in the cycle its own done is high, so a requester that drops req on done is not re-served.
  - If none: stay IDLE.
  - If one: latch its addr, we (0 for f), wdata and owner into addr_q/we_q/wdata_q/own_q, go ISSUE.
  - If both: grant the port not equal to last_grant, update last_grant, go ISSUE.
- ISSUE (1 cycle):
  - mem_adress=addr_q.
  - Read: mem_read=1, mem_write=0.
  - Write: mem_read=0, mem_write=1, mem_indata=wdata_q.
  - busy=1. Next state is CAPTURE.
- CAPTURE (1 cycle):
  - mem_read=0, mem_write=0; mem_adress stays addr_q.
  - At the exit edge, for a read, mem_outdata is loaded into the owner's rdata register.
  - The owner's done is set for exactly the following cycle. Next state is IDLE.
- Latency: request accepted at edge E0 → ISSUE cycle → CAPTURE cycle → done high in the cycle after edge E2 (3 cycles from first IDLE sample). Throughput is one access per 3 cycles.
- A new request may be accepted in the same IDLE cycle that the other port's done is high (back-to-back, no bubble).
- Invariant: mem_read & mem_write is never 1 in any cycle.
- Reset mid-access: the next edge forces IDLE and drops mem_read/mem_write. No done is issued for the aborted access; rdata registers clear to 0.
- Request fields changing after acceptance have no effect: latched copies are used.
- Address wrap: none needed; AW covers the full memory (0x000..0xFFF valid).

Decomposition:
- Shared package (bc_pkg): AW/DW constants, state enum {IDLE, ISSUE, CAPTURE}, owner enum {OWN_F, OWN_D}.
- No sub-module required. Optional round-robin 2-input arbiter sub-module rr_arb2 (req[1:0], last → grant).

Test Plan:
- Pre-load mem[0x010]=0x7800. Assert f_req, f_addr=0x010 → mem_read=1 on the cycle after acceptance; f_done pulses 3 cycles after; f_rdata=0x7800; d_done stays 0.
- d_req=1, d_we=1, d_addr=0xFFF, d_wdata=0xA5A5, then a d read of 0xFFF → first: mem_write=1 for exactly one cycle, mem_read=0. Then d_rdata=0xA5A5 on the second d_done.
- f_req and d_req asserted together from reset, both held → grants d, f, d, f alternating; done pulses 3 cycles apart; f_done and d_done are never high together.
- Requester holds f_req through f_done then drops it → exactly one fetch performed (no duplicate mem_read).
- reset asserted during ISSUE of a write to 0x123 → next cycle mem_write=0, state IDLE, no d_done; busy=0.
- Random 1000-access stream against a memory model → mem_read&mem_write never 1; every read returns the last written value.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// Shared constants and types for the main-memory access controller.
package mem_access_ctrl_pkg;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  typedef enum logic {
    OWN_F = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  // Command latched at acceptance; all later phases use this copy.
  typedef struct packed {
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
    owner_t        own;
  } req_t;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Requester ports (fetch f, data d) plus the memory-side bus of the controller.
interface mem_access_ctrl_if;
  import mem_access_ctrl_pkg::*;

  logic          f_req;
  logic [AW-1:0] f_addr;
  logic          f_done;
  logic [DW-1:0] f_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_done;
  logic [DW-1:0] d_rdata;

  logic          busy;

  logic [AW-1:0] mem_adress;
  logic          mem_read;
  logic          mem_write;
  logic [DW-1:0] mem_indata;
  logic [DW-1:0] mem_outdata;

  // Environment side: requesters and the memory block.
  modport master (
    output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_outdata,
    input  f_done, f_rdata, d_done, d_rdata, busy,
           mem_adress, mem_read, mem_write, mem_indata
  );

  // Controller side.
  modport slave (
    input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_outdata,
    output f_done, f_rdata, d_done, d_rdata, busy,
           mem_adress, mem_read, mem_write, mem_indata
  );
endinterface

// File: rtl/mem_access_ctrl_arb.sv
// Two-input round-robin arbiter: on a tie the port other than the last tie winner wins.
module mem_access_ctrl_arb
  import mem_access_ctrl_pkg::*;
(
  input  logic [1:0] req,    // bit 0 = f, bit 1 = d
  input  owner_t     last,
  output logic       vld_c,
  output logic       tie_c,
  output owner_t     gnt_c
);

  always_comb begin
    vld_c = |req;
    tie_c = &req;
    gnt_c = OWN_F;
    if (tie_c) begin
      if (last == OWN_F) gnt_c = OWN_D;
    end else if (req[1]) begin
      gnt_c = OWN_D;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequences fetch and data accesses to the main memory: accept, issue one command, capture.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  mem_access_ctrl_if.slave   bus
);

  state_t        state;
  owner_t        last_grant;
  owner_t        own_q;
  logic          we_q;
  logic          f_done_q, d_done_q, busy_q;
  logic [DW-1:0] f_rdata_q, d_rdata_q;
  logic [AW-1:0] adr_q;
  logic          rd_q, wr_q;
  logic [DW-1:0] indata_q;

  logic [1:0]    eff_c;
  logic          vld_c, tie_c;
  owner_t        gnt_c;
  req_t          sel_c;

  // A requester is masked while its own done is high so a drop-on-done is not re-served.
  assign eff_c = {bus.d_req & ~d_done_q, bus.f_req & ~f_done_q};

  mem_access_ctrl_arb u_arb (
    .req   (eff_c),
    .last  (last_grant),
    .vld_c (vld_c),
    .tie_c (tie_c),
    .gnt_c (gnt_c)
  );

  always_comb begin
    sel_c.addr  = bus.f_addr;
    sel_c.we    = 1'b0;
    sel_c.wdata = bus.d_wdata;
    sel_c.own   = OWN_F;
    if (gnt_c == OWN_D) begin
      sel_c.addr = bus.d_addr;
      sel_c.we   = bus.d_we;
      sel_c.own  = OWN_D;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= OWN_F;
      own_q      <= OWN_F;
      we_q       <= 1'b0;
      f_done_q   <= 1'b0;
      d_done_q   <= 1'b0;
      busy_q     <= 1'b0;
      f_rdata_q  <= '0;
      d_rdata_q  <= '0;
      adr_q      <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      indata_q   <= '0;
    end else begin
      f_done_q <= 1'b0;
      d_done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (vld_c) begin
            own_q  <= sel_c.own;
            we_q   <= sel_c.we;
            adr_q  <= sel_c.addr;
            rd_q   <= ~sel_c.we;
            wr_q   <= sel_c.we;
            busy_q <= 1'b1;
            state  <= ISSUE;
            if (sel_c.we) indata_q <= sel_c.wdata;
            if (tie_c)    last_grant <= sel_c.own;
          end
        end
        ISSUE: begin
          rd_q  <= 1'b0;
          wr_q  <= 1'b0;
          state <= CAPTURE;
        end
        CAPTURE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
          // Memory outdata was updated at the ISSUE exit edge and is stable now.
          if (own_q == OWN_F) begin
            f_done_q <= 1'b1;
            if (!we_q) f_rdata_q <= bus.mem_outdata;
          end else begin
            d_done_q <= 1'b1;
            if (!we_q) d_rdata_q <= bus.mem_outdata;
          end
        end
        default: begin
          rd_q   <= 1'b0;
          wr_q   <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.f_done     = f_done_q;
  assign bus.f_rdata    = f_rdata_q;
  assign bus.d_done     = d_done_q;
  assign bus.d_rdata    = d_rdata_q;
  assign bus.busy       = busy_q;
  assign bus.mem_adress = adr_q;
  assign bus.mem_read   = rd_q;
  assign bus.mem_write  = wr_q;
  assign bus.mem_indata = indata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: directed cases plus a randomized two-port stream.
module tb_mem_access_ctrl;

  typedef struct {
    logic        is_rd;
    logic [15:0] data;
  } exp_t;

  logic clk;
  logic reset;

  mem_access_ctrl_if bus ();

  mem_access_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [15:0] mem    [4096];
  logic [15:0] shadow [4096];

  exp_t exp_f[$];
  exp_t exp_d[$];

  int compared      = 0;
  int mismatched    = 0;
  int rd_pulses     = 0;
  int wr_pulses     = 0;
  int reads_issued  = 0;
  int writes_issued = 0;
  logic        rst_q;
  logic [15:0] d_hold;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory block model: registered outdata, write on posedge.
  always @(posedge clk) begin
    rst_q <= reset;
    if (bus.mem_read)  bus.mem_outdata <= mem[bus.mem_adress];
    if (bus.mem_write) mem[bus.mem_adress] = bus.mem_indata;
  end

  // Monitor: invariants every cycle, scoreboard pop on each done.
  always @(negedge clk) begin
    exp_t e;
    if (rst_q) begin
      d_hold = 16'h0000;
    end else begin
      if (bus.mem_read)  rd_pulses++;
      if (bus.mem_write) wr_pulses++;
      if (bus.mem_read && bus.mem_write) begin
        compared++; mismatched++;
        $display("FAIL rd_wr_excl: mem_read=1 and mem_write=1 at %0t", $time);
      end
      if (bus.f_done && bus.d_done) begin
        compared++; mismatched++;
        $display("FAIL done_excl: f_done=1 and d_done=1 at %0t", $time);
      end
      if (bus.f_done) begin
        compared++;
        if (exp_f.size() == 0) begin
          mismatched++;
          $display("FAIL f_unexpected: f_done=1 with no fetch pending at %0t", $time);
        end else begin
          e = exp_f.pop_front();
          if (bus.f_rdata !== e.data) begin
            mismatched++;
            $display("FAIL f_rdata: got %h want %h at %0t", bus.f_rdata, e.data, $time);
          end
        end
      end
      if (bus.d_done) begin
        compared++;
        if (exp_d.size() == 0) begin
          mismatched++;
          $display("FAIL d_unexpected: d_done=1 with no data access pending at %0t", $time);
        end else begin
          e = exp_d.pop_front();
          if (e.is_rd) d_hold = e.data;
          if (bus.d_rdata !== d_hold) begin
            mismatched++;
            $display("FAIL d_rdata: got %h want %h (read=%0d) at %0t",
                     bus.d_rdata, d_hold, e.is_rd, $time);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  task automatic f_read(input logic [11:0] a);
    int lat;
    exp_t e;
    bus.f_req  = 1'b1;
    bus.f_addr = a;
    e.is_rd = 1'b1;
    e.data  = shadow[a];
    exp_f.push_back(e);
    reads_issued++;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!bus.f_done && lat < 20);
    compared++;
    if (!bus.f_done || lat < 3 || lat > 7) begin
      mismatched++;
      $display("FAIL f_latency: addr %h got %0d cycles want 3..7", a, lat);
    end
    bus.f_req = 1'b0;
  endtask

  task automatic d_access(input logic we, input logic [11:0] a, input logic [15:0] w);
    int lat;
    exp_t e;
    bus.d_req   = 1'b1;
    bus.d_we    = we;
    bus.d_addr  = a;
    bus.d_wdata = w;
    e.is_rd = ~we;
    if (we) begin
      shadow[a] = w;
      e.data = 16'h0000;
      writes_issued++;
    end else begin
      e.data = shadow[a];
      reads_issued++;
    end
    exp_d.push_back(e);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!bus.d_done && lat < 20);
    compared++;
    if (!bus.d_done || lat < 3 || lat > 7) begin
      mismatched++;
      $display("FAIL d_latency: addr %h got %0d cycles want 3..7", a, lat);
    end
    bus.d_req = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd0, wr0, nf, nd;
    int   ev_cyc[$];
    logic ev_d[$];

    reset = 1'b1;
    bus.f_req = 1'b0; bus.f_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.mem_outdata = '0;
    for (int i = 0; i < 4096; i++) begin
      shadow[i] = 16'($urandom);
      mem[i]    = shadow[i];
    end
    shadow[12'h010] = 16'h7800;
    mem[12'h010]    = 16'h7800;

    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_f_done",  32'(bus.f_done),     32'd0);
    check("rst_d_done",  32'(bus.d_done),     32'd0);
    check("rst_f_rdata", 32'(bus.f_rdata),    32'd0);
    check("rst_d_rdata", 32'(bus.d_rdata),    32'd0);
    check("rst_busy",    32'(bus.busy),       32'd0);
    check("rst_rd",      32'(bus.mem_read),   32'd0);
    check("rst_wr",      32'(bus.mem_write),  32'd0);
    check("rst_adr",     32'(bus.mem_adress), 32'd0);
    check("rst_indata",  32'(bus.mem_indata), 32'd0);

    // Single fetch with cycle-exact checks.
    rd0 = rd_pulses;
    bus.f_req = 1'b1; bus.f_addr = 12'h010;
    exp_f.push_back('{is_rd: 1'b1, data: 16'h7800});
    reads_issued++;
    @(negedge clk);
    check("fetch_issue_rd",  32'(bus.mem_read),   32'd1);
    check("fetch_issue_wr",  32'(bus.mem_write),  32'd0);
    check("fetch_issue_adr", 32'(bus.mem_adress), 32'h010);
    check("fetch_issue_busy",32'(bus.busy),       32'd1);
    @(negedge clk);
    check("fetch_cap_rd",    32'(bus.mem_read),   32'd0);
    check("fetch_cap_busy",  32'(bus.busy),       32'd1);
    @(negedge clk);
    check("fetch_done",      32'(bus.f_done),     32'd1);
    check("fetch_rdata",     32'(bus.f_rdata),    32'h7800);
    check("fetch_d_done",    32'(bus.d_done),     32'd0);
    bus.f_req = 1'b0;
    repeat (3) @(negedge clk);
    check("fetch_single_rd", 32'(rd_pulses - rd0), 32'd1);
    check("fetch_done_off",  32'(bus.f_done),     32'd0);

    // Write to the top address; fields scrambled after acceptance must not matter.
    rd0 = rd_pulses; wr0 = wr_pulses;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 12'hFFF; bus.d_wdata = 16'hA5A5;
    shadow[12'hFFF] = 16'hA5A5;
    exp_d.push_back('{is_rd: 1'b0, data: 16'h0000});
    writes_issued++;
    @(negedge clk);
    check("wr_issue_wr",  32'(bus.mem_write),  32'd1);
    check("wr_issue_rd",  32'(bus.mem_read),   32'd0);
    check("wr_issue_adr", 32'(bus.mem_adress), 32'hFFF);
    check("wr_issue_dat", 32'(bus.mem_indata), 32'hA5A5);
    bus.d_addr = 12'h000; bus.d_wdata = 16'h1234; bus.d_we = 1'b0;
    @(negedge clk);
    check("wr_cap_wr",    32'(bus.mem_write),  32'd0);
    @(negedge clk);
    check("wr_done",      32'(bus.d_done),     32'd1);
    bus.d_req = 1'b0;
    check("wr_one_pulse", 32'(wr_pulses - wr0), 32'd1);
    check("wr_no_read",   32'(rd_pulses - rd0), 32'd0);
    d_access(1'b0, 12'hFFF, 16'h0000);
    check("rd_back_fff",  32'(bus.d_rdata),    32'hA5A5);
    check("mem_fff",      32'(mem[12'hFFF]),   32'hA5A5);

    // Reset during ISSUE of a write aborts it without a done.
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 12'h123; bus.d_wdata = 16'h5A5A;
    shadow[12'h123] = 16'h5A5A;
    writes_issued++;
    @(negedge clk);
    check("abort_issue_wr", 32'(bus.mem_write), 32'd1);
    reset = 1'b1; bus.d_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check("abort_wr",      32'(bus.mem_write), 32'd0);
    check("abort_rd",      32'(bus.mem_read),  32'd0);
    check("abort_busy",    32'(bus.busy),      32'd0);
    check("abort_d_done",  32'(bus.d_done),    32'd0);
    check("abort_d_rdata", 32'(bus.d_rdata),   32'd0);
    check("abort_f_rdata", 32'(bus.f_rdata),   32'd0);
    repeat (5) @(negedge clk);

    // Both requesting from reset: d first, then alternation, 3 cycles apart.
    bus.f_req = 1'b1; bus.f_addr = 12'h020;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 12'h800;
    for (int k = 0; k < 2; k++) begin
      exp_f.push_back('{is_rd: 1'b1, data: shadow[12'h020]});
      exp_d.push_back('{is_rd: 1'b1, data: shadow[12'h800]});
    end
    reads_issued += 4;
    nf = 0; nd = 0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (bus.d_done) begin
        ev_cyc.push_back(c); ev_d.push_back(1'b1); nd++;
        if (nd == 2) bus.d_req = 1'b0;
      end
      if (bus.f_done) begin
        ev_cyc.push_back(c); ev_d.push_back(1'b0); nf++;
        if (nf == 2) bus.f_req = 1'b0;
      end
    end
    bus.f_req = 1'b0; bus.d_req = 1'b0;
    check("rr_events", 32'(ev_cyc.size()), 32'd4);
    for (int k = 0; k < ev_cyc.size() && k < 4; k++) begin
      check($sformatf("rr_cycle%0d", k), 32'(ev_cyc[k]), 32'(3 * (k + 1)));
      check($sformatf("rr_owner%0d", k), 32'(ev_d[k]),   32'((k % 2) == 0));
    end

    // Random stream: f reads the low half, d reads/writes the high half.
    @(negedge clk);
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          f_read(12'($urandom_range(0, 2047)));
          repeat ($urandom_range(0, 3)) @(negedge clk);
        end
      end
      begin
        for (int i = 0; i < 600; i++) begin
          d_access(1'($urandom_range(0, 1)), 12'($urandom_range(2048, 4095)), 16'($urandom));
          repeat ($urandom_range(0, 3)) @(negedge clk);
        end
      end
    join

    repeat (8) @(negedge clk);
    check("total_reads",  32'(rd_pulses),    32'(reads_issued));
    check("total_writes", 32'(wr_pulses),    32'(writes_issued));
    check("f_queue_left", 32'(exp_f.size()), 32'd0);
    check("d_queue_left", 32'(exp_d.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
